serial_sub_unit: RTL and testbench



---
 rtl/serial_sub_unit.sv | 98 +++++++++
 tb/tb_serial_sub_unit.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_sub_unit.sv
// Bit-serial subtractor: diff = a - b, LSB first, one full-subtractor cell per clock.
// An IDLE/RUN/DONE controller sequences it with a start/busy/done handshake.
module serial_sub_unit #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out,
  output logic             overflow
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

  state_t          state, next_state;
  logic [WIDTH-1:0] sa, sb, res;
  logic [CW-1:0]    cnt;
  logic             br;
  logic             a_msb, b_msb;
  logic             x, y, d, br_next;
  logic             accept, last_bit;

  assign x       = sa[0];
  assign y       = sb[0];
  assign d       = x ^ y ^ br;
  assign br_next = (~x & y) | (~(x ^ y) & br);

  assign accept   = start && ((state == IDLE) || (state == DONE));
  assign last_bit = (state == RUN) && (cnt == LAST);

  assign busy = (state == RUN);
  assign done = (state == DONE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (start) next_state = RUN;
      RUN:     if (cnt == LAST) next_state = DONE;
      DONE:    next_state = start ? RUN : IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Operand MSBs are kept aside because sa/sb are consumed by the shifting.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sa         <= '0;
      sb         <= '0;
      res        <= '0;
      cnt        <= '0;
      br         <= 1'b0;
      a_msb      <= 1'b0;
      b_msb      <= 1'b0;
      diff       <= '0;
      borrow_out <= 1'b0;
      overflow   <= 1'b0;
    end else if (accept) begin
      sa    <= a;
      sb    <= b;
      br    <= 1'b0;
      cnt   <= '0;
      a_msb <= a[WIDTH-1];
      b_msb <= b[WIDTH-1];
    end else if (state == RUN) begin
      res <= {d, res[WIDTH-1:1]};
      sa  <= {1'b0, sa[WIDTH-1:1]};
      sb  <= {1'b0, sb[WIDTH-1:1]};
      br  <= br_next;
      cnt <= cnt + CW'(1);
      if (last_bit) begin
        diff       <= {d, res[WIDTH-1:1]};
        borrow_out <= br_next;
        overflow   <= (a_msb != b_msb) && (d != a_msb);
      end
    end
  end

endmodule

// File: tb/tb_serial_sub_unit.sv
// Self-checking bench for serial_sub_unit: scoreboard of expected results,
// one task per scenario, compared when done pulses.
module tb_serial_sub_unit;

  localparam int W = 8;

  logic         clk;
  logic         reset;
  logic         start;
  logic [W-1:0] a, b;
  logic         busy, done;
  logic [W-1:0] diff;
  logic         borrow_out, overflow;

  typedef struct packed {
    logic [W-1:0] d;
    logic         bo;
    logic         ov;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;
  int   protocol_viol = 0;
  logic prev_done = 1'b0;

  serial_sub_unit #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .start(start), .a(a), .b(b),
    .busy(busy), .done(done), .diff(diff),
    .borrow_out(borrow_out), .overflow(overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Handshake invariants watched for the whole run.
  always @(negedge clk) begin
    if (busy === 1'b1 && done === 1'b1) protocol_viol++;
    if (prev_done === 1'b1 && done === 1'b1) protocol_viol++;
    prev_done = done;
  end

  function automatic exp_t model(input logic [W-1:0] av, input logic [W-1:0] bv);
    exp_t e;
    e.d  = av - bv;
    e.bo = (av < bv);
    e.ov = (av[W-1] != bv[W-1]) && (e.d[W-1] != av[W-1]);
    return e;
  endfunction

  // Presents one operation for a single accepting edge; returns just after that edge.
  task automatic start_op(input logic [W-1:0] av, input logic [W-1:0] bv);
    @(negedge clk);
    start = 1'b1;
    a = av;
    b = bv;
    sb_q.push_back(model(av, bv));
    @(posedge clk);
    #1;
    start = 1'b0;
    a = W'($urandom);
    b = W'($urandom);
  endtask

  task automatic wait_done(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    start = 1'b0;
    a = '0;
    b = '0;
    repeat (3) @(negedge clk);
    checks++;
    if ({busy, done, diff, borrow_out, overflow} !== '0) begin
      errors++;
      $display("[TB] FAIL reset_state: got busy=%b done=%b diff=%h bo=%b ov=%b, want all 0",
               busy, done, diff, borrow_out, overflow);
    end
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("[TB] FAIL idle_after_reset: got busy=%b done=%b, want 0 0", busy, done);
    end
  endtask

  task automatic test_basic();
    int   busy_cnt = 0;
    int   done_cnt = 0;
    int   done_at = -1;
    exp_t obs = 'x;
    exp_t exp;
    start_op(8'h05, 8'h03);
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (busy === 1'b1) busy_cnt++;
      if (done === 1'b1) begin
        done_cnt++;
        done_at = k;
        obs = {diff, borrow_out, overflow};
      end
    end
    exp = sb_q.pop_front();
    checks++;
    if (busy_cnt != W) begin
      errors++;
      $display("[TB] FAIL basic_busy_len: got %0d cycles, want %0d", busy_cnt, W);
    end
    checks++;
    if (done_cnt != 1 || done_at != W + 1) begin
      errors++;
      $display("[TB] FAIL basic_done_timing: got %0d pulses at cycle %0d, want 1 at %0d",
               done_cnt, done_at, W + 1);
    end
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL basic_result: got diff=%h bo=%b ov=%b, want diff=%h bo=%b ov=%b",
               obs.d, obs.bo, obs.ov, exp.d, exp.bo, exp.ov);
    end
  endtask

  // Fixed corner cases: borrow, zero, and both signed-overflow directions.
  task automatic test_corners();
    logic [W-1:0] tbl_a[4] = '{8'h03, 8'h00, 8'h80, 8'h7F};
    logic [W-1:0] tbl_b[4] = '{8'h05, 8'h00, 8'h01, 8'hFF};
    bit   ok;
    exp_t exp;
    for (int i = 0; i < 4; i++) begin
      start_op(tbl_a[i], tbl_b[i]);
      wait_done(ok);
      exp = sb_q.pop_front();
      checks++;
      if (!ok) begin
        errors++;
        $display("[TB] FAIL corner_timeout[%0d]: got no done, want done", i);
      end else if ({diff, borrow_out, overflow} !== exp) begin
        errors++;
        $display("[TB] FAIL corner_result[%0d]: got diff=%h bo=%b ov=%b, want diff=%h bo=%b ov=%b",
                 i, diff, borrow_out, overflow, exp.d, exp.bo, exp.ov);
      end
    end
  endtask

  task automatic test_back_to_back();
    bit   ok;
    exp_t exp;
    start_op(8'h10, 8'h01);
    repeat (2) @(negedge clk);
    start = 1'b1;
    a = 8'hFF;
    b = 8'hFF;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    start = 1'b1;
    a = 8'h20;
    b = 8'h20;
    sb_q.push_back(model(8'h20, 8'h20));
    wait_done(ok);
    exp = sb_q.pop_front();
    checks++;
    if (!ok) begin
      errors++;
      $display("[TB] FAIL b2b_first_timeout: got no done, want done");
    end else if ({diff, borrow_out, overflow} !== exp) begin
      errors++;
      $display("[TB] FAIL b2b_first_result: got diff=%h bo=%b ov=%b, want diff=%h bo=%b ov=%b",
               diff, borrow_out, overflow, exp.d, exp.bo, exp.ov);
    end
    @(posedge clk);
    #1;
    start = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("[TB] FAIL b2b_no_idle: got busy=%b after DONE, want 1", busy);
    end
    checks++;
    if (diff !== 8'h0F) begin
      errors++;
      $display("[TB] FAIL b2b_hold_during_run: got diff=%h, want 0f", diff);
    end
    wait_done(ok);
    exp = sb_q.pop_front();
    checks++;
    if (!ok) begin
      errors++;
      $display("[TB] FAIL b2b_second_timeout: got no done, want done");
    end else if ({diff, borrow_out, overflow} !== exp) begin
      errors++;
      $display("[TB] FAIL b2b_second_result: got diff=%h bo=%b ov=%b, want diff=%h bo=%b ov=%b",
               diff, borrow_out, overflow, exp.d, exp.bo, exp.ov);
    end
  endtask

  task automatic test_async_reset();
    bit   ok;
    int   stray = 0;
    exp_t exp;
    start_op(8'h7F, 8'hFF);
    wait_done(ok);
    exp = sb_q.pop_front();
    checks++;
    if (!ok || {diff, borrow_out, overflow} !== exp) begin
      errors++;
      $display("[TB] FAIL prereset_result: got ok=%b diff=%h bo=%b ov=%b, want diff=%h bo=%b ov=%b",
               ok, diff, borrow_out, overflow, exp.d, exp.bo, exp.ov);
    end
    start_op(8'h55, 8'h11);
    repeat (4) @(negedge clk);
    #2;
    reset = 1'b1;
    sb_q.delete();
    #1;
    checks++;
    if ({busy, done, diff, borrow_out, overflow} !== '0) begin
      errors++;
      $display("[TB] FAIL async_reset_clear: got busy=%b done=%b diff=%h bo=%b ov=%b, want all 0",
               busy, done, diff, borrow_out, overflow);
    end
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) stray++;
    end
    checks++;
    if (stray != 0) begin
      errors++;
      $display("[TB] FAIL post_reset_quiet: got %0d busy/done cycles, want 0", stray);
    end
  endtask

  task automatic test_random();
    bit   ok;
    int   accepts = 0;
    int   dones = 0;
    int   bad = 0;
    exp_t exp;
    for (int i = 0; i < 200; i++) begin
      start_op(W'($urandom), W'($urandom));
      accepts++;
      wait_done(ok);
      exp = sb_q.pop_front();
      if (ok) dones++;
      checks++;
      if (!ok || {diff, borrow_out, overflow} !== exp) begin
        errors++;
        bad++;
        if (bad <= 5)
          $display("[TB] FAIL random_result[%0d]: got ok=%b diff=%h bo=%b ov=%b, want diff=%h bo=%b ov=%b",
                   i, ok, diff, borrow_out, overflow, exp.d, exp.bo, exp.ov);
      end
    end
    checks++;
    if (dones != accepts) begin
      errors++;
      $display("[TB] FAIL random_done_count: got %0d dones, want %0d", dones, accepts);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_corners();
    test_back_to_back();
    test_async_reset();
    test_random();
    checks++;
    if (protocol_viol != 0) begin
      errors++;
      $display("[TB] FAIL handshake_protocol: got %0d violations, want 0", protocol_viol);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
